queue_access_arbiter: RTL and testbench
=======================================

Name: queue_access_arbiter

Overview:
- Shares one bounded, index-addressable integer queue between two requesters.
- Arbitrates round-robin and sequences one operation per cycle: PUSH (tail), POP (head) or READ (element at an index from head).
- Returns a registered response one cycle after acceptance.
- Sits in front of element-select queue storage so multiple producer/consumer agents can use it without conflict.

Parameters:
- DEPTH, 8, queue capacity in entries; power of two, at least 2.
- DATA_W, 32, element width (int-sized by default).
- IDX_W, 3, index width; equals log2(DEPTH).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  2  per-requester request valid; bit i is requester i.
- req_op  input  4  per-requester opcode, [2i+1:2i]. 01 PUSH, 10 POP, 11 READ, 00 NOP (treated as not valid).
- req_data  input  2*DATA_W  per-requester push data, slice i.
- req_index  input  2*IDX_W  per-requester READ index, slice i.
- req_ready  output  2  one-hot grant; combinational from req_valid, req_op and the priority pointer.
- rsp_valid  output  1  response valid, exactly one cycle per accepted op.
- rsp_id  output  1  requester that issued the responded op.
- rsp_data  output  DATA_W  POP or READ data; 0 for PUSH or error.
- rsp_err  output  1  op was rejected.
- q_size  output  IDX_W+1  current occupancy, 0..DEPTH.
- full  output  1  q_size == DEPTH.
- empty  output  1  q_size == 0.

Behaviour:
- Reset (async, rst=1) clears state immediately:
  - head=0, tail=0, count=0, priority pointer=0 (requester 0 favoured).
  - rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0.
  - q_size=0, empty=1, full=0.
  - Storage contents are don't-care.
- Active request: req_valid[i]=1 and opcode != 00.
- Arbitration:
  - If only one requester is active, it is granted.
  - If both are active, the one at the priority pointer is granted.
  - After any accepted op, the pointer moves to the non-granted requester.
  - With no grant, the pointer holds.
  - At most one req_ready bit is high. req_ready is 0 for any inactive requester.
- Acceptance: valid & ready at a rising edge. A requester not granted must hold its request; no ordering guarantee is given to it beyond round-robin fairness.
- PUSH:
  - Not full: write storage[tail], tail=tail+1 mod DEPTH, count+1, rsp_err=0, rsp_data=0.
  - Full: no state change, rsp_err=1.
- POP:
  - Not empty: rsp_data=storage[head], head=head+1 mod DEPTH, count-1, rsp_err=0.
  - Empty: rsp_err=1, rsp_data=0.
- READ:
  - index < count: rsp_data=storage[(head+index) mod DEPTH], rsp_err=0, no state change.
  - Otherwise: rsp_err=1, rsp_data=0.
- Rejected ops consume the grant and rotate the priority pointer.
- Latency: response registered at the acceptance edge, so rsp_* are visible the cycle after the handshake. rsp_valid deasserts the next cycle if nothing is accepted. There is no response backpressure.
- READ/POP results reflect state before the same-edge update; there is only one op per cycle, so there are no intra-cycle hazards.
- q_size/full/empty are registered from count and update at the acceptance edge.
- Pointer wrap: tail/head wrap DEPTH-1 to 0. Index arithmetic is modulo DEPTH.
- Reset asserted mid-operation: an in-flight response is dropped (rsp_valid=0) and the queue empties. No grant while rst=1.

Test Plan:
- Reset, then req0 PUSH 5, 7, 9 back-to-back -> three rsp_valid pulses with rsp_id=0, rsp_err=0; q_size 1, 2, 3; then req1 READ index 1 -> rsp_data=7, q_size stays 3.
- Both requesters PUSH every cycle for 4 cycles -> grants alternate 0,1,0,1; the following POPs return the data in that order.
- Fill to DEPTH=8 and PUSH once more -> rsp_err=1, q_size=8, full=1. POP on empty -> rsp_err=1, rsp_data=0, empty=1.
- PUSH 8, POP 5, PUSH 5 (forces wrap) -> READ indices 0..7 return the FIFO-ordered values; READ index 8-q_size boundary (index == count) -> rsp_err=1.
- Opcode 00 with valid=1 on req0 while req1 PUSHes -> req1 granted, req0 req_ready=0, priority rotates only on req1 acceptance.
- Assert rst for one cycle with q_size=4 and rsp_valid=1 -> outputs clear asynchronously; after release, req1 POP -> rsp_err=1.

Source files
------------

// File: rtl/queue_access_arbiter.sv
// queue_access_arbiter
//
// Shares one bounded, index-addressable queue between two requesters.
// Each cycle at most one request is granted, round-robin, and executed:
// PUSH at the tail, POP from the head, or READ of the element `index`
// positions behind the head. The result is registered at the acceptance
// edge and presented on rsp_* for exactly one cycle.
//
// Handshake: a request from requester i is active when req_valid[i]=1 and
// its opcode is not NOP. It is accepted on a rising clk edge where
// req_valid[i] & req_ready[i] are both high. A requester that is not
// granted keeps its request (valid, op, data, index) stable until it is
// granted. There is no backpressure on the response channel.
//
// Ports:
//   clk, rst     clock (rising edge), asynchronous active-high reset
//   req_valid    [1:0]          per-requester request valid
//   req_op       [3:0]          opcode of requester i in [2i+1:2i]
//                               01 PUSH, 10 POP, 11 READ, 00 NOP
//   req_data     [2*DATA_W-1:0] push data of requester i in slice i
//   req_index    [2*IDX_W-1:0]  READ index of requester i in slice i
//   req_ready    [1:0]          one-hot grant (combinational)
//   rsp_valid                   one-cycle response strobe
//   rsp_id                      requester that issued the responded op
//   rsp_data     [DATA_W-1:0]   POP/READ data, 0 for PUSH or error
//   rsp_err                     op was rejected (full/empty/bad index)
//   q_size       [IDX_W:0]      occupancy 0..DEPTH
//   full, empty                 q_size == DEPTH, q_size == 0
module queue_access_arbiter #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid,
  input  logic [3:0]            req_op,
  input  logic [2*DATA_W-1:0]   req_data,
  input  logic [2*IDX_W-1:0]    req_index,
  output logic [1:0]            req_ready,
  output logic                  rsp_valid,
  output logic                  rsp_id,
  output logic [DATA_W-1:0]     rsp_data,
  output logic                  rsp_err,
  output logic [IDX_W:0]        q_size,
  output logic                  full,
  output logic                  empty
);

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_POP  = 2'b10;
  localparam logic [1:0] OP_READ = 2'b11;

  localparam logic [IDX_W:0]   DEPTH_C = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0]   CNT_ONE = (IDX_W+1)'(1);
  localparam logic [IDX_W-1:0] PTR_ONE = IDX_W'(1);

  // Storage has no reset; its contents only matter once written.
  logic [DATA_W-1:0] mem [DEPTH];

  logic [IDX_W-1:0] head;
  logic [IDX_W-1:0] tail;
  logic [IDX_W:0]   count;
  logic             prio;     // requester favoured when both are active

  logic [1:0]        active;
  logic [1:0]        gnt;
  logic              accept;
  logic              gnt_id;
  logic [1:0]        sel_op;
  logic [DATA_W-1:0] sel_data;
  logic [IDX_W-1:0]  sel_index;
  logic [IDX_W-1:0]  rd_addr;
  logic              is_full;
  logic              is_empty;
  logic              do_write;
  logic              do_pop;
  logic              op_err;
  logic [DATA_W-1:0] op_data;
  logic [IDX_W:0]    count_nxt;

  // NOP with valid=1 is not a request: it never competes for the grant.
  always_comb begin
    active[0] = req_valid[0] && (req_op[1:0] != OP_NOP);
    active[1] = req_valid[1] && (req_op[3:2] != OP_NOP);
  end

  // Round-robin grant; nothing is granted while reset is held.
  always_comb begin
    gnt = 2'b00;
    if (!rst) begin
      if (active == 2'b11) gnt = prio ? 2'b10 : 2'b01;
      else                 gnt = active;
    end
  end

  assign req_ready = gnt;
  assign accept    = |gnt;
  assign gnt_id    = gnt[1];

  // Mux the granted requester's fields.
  always_comb begin
    sel_op    = gnt_id ? req_op[3:2]               : req_op[1:0];
    sel_data  = gnt_id ? req_data[2*DATA_W-1:DATA_W] : req_data[DATA_W-1:0];
    sel_index = gnt_id ? req_index[2*IDX_W-1:IDX_W]  : req_index[IDX_W-1:0];
  end

  assign is_full  = (count == DEPTH_C);
  assign is_empty = (count == '0);
  // Pointer width equals log2(DEPTH), so the add wraps modulo DEPTH.
  assign rd_addr  = head + sel_index;

  // Execute the granted op against the pre-edge queue state.
  always_comb begin
    do_write = 1'b0;
    do_pop   = 1'b0;
    op_err   = 1'b0;
    op_data  = '0;
    case (sel_op)
      OP_PUSH: begin
        if (is_full) op_err = 1'b1;
        else         do_write = 1'b1;
      end
      OP_POP: begin
        if (is_empty) op_err = 1'b1;
        else begin
          do_pop  = 1'b1;
          op_data = mem[head];
        end
      end
      OP_READ: begin
        if ({1'b0, sel_index} < count) op_data = mem[rd_addr];
        else                           op_err  = 1'b1;
      end
      default: ;
    endcase
    if (!accept) begin
      do_write = 1'b0;
      do_pop   = 1'b0;
    end
  end

  always_comb begin
    count_nxt = count;
    if (do_write)    count_nxt = count + CNT_ONE;
    else if (do_pop) count_nxt = count - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (do_write) mem[tail] <= sel_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      prio      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      full      <= 1'b0;
      empty     <= 1'b1;
    end else begin
      rsp_valid <= accept;
      if (accept) begin
        rsp_id   <= gnt_id;
        rsp_data <= op_data;
        rsp_err  <= op_err;
        // Rejected ops still consume the grant and rotate priority.
        prio     <= ~gnt_id;
      end
      if (do_write) tail <= tail + PTR_ONE;
      if (do_pop)   head <= head + PTR_ONE;
      count <= count_nxt;
      full  <= (count_nxt == DEPTH_C);
      empty <= (count_nxt == '0);
    end
  end

  assign q_size = count;

endmodule

// File: tb/tb_queue_access_arbiter.sv
module tb_queue_access_arbiter;

  localparam int DW = 32;
  localparam int IW = 3;
  localparam int EW = 2 + DW + IW + 1;  // {id, err, data, q_size}

  localparam logic [1:0] NOP  = 2'b00;
  localparam logic [1:0] PUSH = 2'b01;
  localparam logic [1:0] POP  = 2'b10;
  localparam logic [1:0] READ = 2'b11;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // per-requester drive state
  logic          rv  [2];
  logic [1:0]    rop [2];
  logic [DW-1:0] rd  [2];
  logic [IW-1:0] ri  [2];

  logic [1:0]      req_valid;
  logic [3:0]      req_op;
  logic [2*DW-1:0] req_data;
  logic [2*IW-1:0] req_index;
  logic [1:0]      req_ready;
  logic            rsp_valid;
  logic            rsp_id;
  logic [DW-1:0]   rsp_data;
  logic            rsp_err;
  logic [IW:0]     q_size;
  logic            full;
  logic            empty;

  assign req_valid = {rv[1], rv[0]};
  assign req_op    = {rop[1], rop[0]};
  assign req_data  = {rd[1], rd[0]};
  assign req_index = {ri[1], ri[0]};

  queue_access_arbiter #(.DEPTH(8), .DATA_W(DW), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_op(req_op), .req_data(req_data), .req_index(req_index),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .q_size(q_size), .full(full), .empty(empty)
  );

  int total = 0;
  int bad   = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_e;

  function automatic logic [EW-1:0] pack(input logic id, input logic err,
                                         input logic [DW-1:0] d, input logic [IW:0] qs);
    return {id, err, d, qs};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h need %0h", name, act, req);
    end
  endtask

  task automatic expect_rsp(input logic id, input logic err, input int d, input int qs);
    exp_q.push_back(pack(id, err, DW'(d), (IW+1)'(qs)));
  endtask

  // Driver: called at posedge+#1; holds the request until granted.
  task automatic do_op(input int r, input logic [1:0] op, input int d, input int idx);
    bit done = 0;
    rv[r] = 1'b1; rop[r] = op; rd[r] = DW'(d); ri[r] = IW'(idx);
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      if (req_ready[r] === 1'b1) done = 1;
      @(posedge clk);
      #1;
    end
    rv[r] = 1'b0; rop[r] = NOP;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL grant_timeout: req%0d got no grant, need grant within 20 cycles", r);
    end
  endtask

  task automatic op_exp(input int r, input logic [1:0] op, input int d, input int idx,
                        input logic eid, input logic eerr, input int edata, input int eqs);
    expect_rsp(eid, eerr, edata, eqs);
    do_op(r, op, d, idx);
  endtask

  // Monitor: every response is popped and compared against the scoreboard.
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL rsp_unexpected: got id=%0d err=%0d data=%0h qs=%0d, need no response",
                 rsp_id, rsp_err, rsp_data, q_size);
      end else begin
        exp_e = exp_q.pop_front();
        if ({rsp_id, rsp_err, rsp_data, q_size} !== exp_e) begin
          bad++;
          $display("FAIL rsp: got id=%0d err=%0d data=%0h qs=%0d, need id=%0d err=%0d data=%0h qs=%0d",
                   rsp_id, rsp_err, rsp_data, q_size,
                   exp_e[EW-1], exp_e[EW-2], exp_e[IW+DW:IW+1], exp_e[IW:0]);
        end
      end
    end
  end

  int rd_tab[8] = '{25, 26, 27, 30, 31, 32, 33, 34};

  initial begin
    for (int i = 0; i < 2; i++) begin
      rv[i] = 1'b0; rop[i] = NOP; rd[i] = '0; ri[i] = '0;
    end
    rst = 1'b1;
    rv[0] = 1'b1; rop[0] = PUSH;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", req_ready, 2'b00);
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_q_size", q_size, 0);
    chk("reset_empty", empty, 1'b1);
    chk("reset_full", full, 1'b0);
    rv[0] = 1'b0; rop[0] = NOP;
    rst = 1'b0;
    @(posedge clk); #1;

    // back-to-back pushes by req0, then READ index 1 by req1
    op_exp(0, PUSH, 5, 0, 0, 0, 0, 1);
    op_exp(0, PUSH, 7, 0, 0, 0, 0, 2);
    op_exp(0, PUSH, 9, 0, 0, 0, 0, 3);
    op_exp(1, READ, 0, 1, 1, 0, 7, 3);
    // drain via req1 so priority points at req0
    op_exp(1, POP, 0, 0, 1, 0, 5, 2);
    op_exp(1, POP, 0, 0, 1, 0, 7, 1);
    op_exp(1, POP, 0, 0, 1, 0, 9, 0);

    // both push concurrently: grants 0,1,0,1
    expect_rsp(0, 0, 0, 1);
    expect_rsp(1, 0, 0, 2);
    expect_rsp(0, 0, 0, 3);
    expect_rsp(1, 0, 0, 4);
    fork
      begin do_op(0, PUSH, 'h100, 0); do_op(0, PUSH, 'h101, 0); end
      begin do_op(1, PUSH, 'h200, 0); do_op(1, PUSH, 'h201, 0); end
    join
    op_exp(0, POP, 0, 0, 0, 0, 'h100, 3);
    op_exp(0, POP, 0, 0, 0, 0, 'h200, 2);
    op_exp(0, POP, 0, 0, 0, 0, 'h101, 1);
    op_exp(0, POP, 0, 0, 0, 0, 'h201, 0);

    // fill, overflow, drain, underflow
    for (int k = 0; k < 8; k++) op_exp(0, PUSH, 10 + k, 0, 0, 0, 0, k + 1);
    chk("full_at_8", full, 1'b1);
    op_exp(0, PUSH, 99, 0, 0, 1, 0, 8);
    chk("full_after_reject", full, 1'b1);
    for (int k = 0; k < 8; k++) op_exp(0, POP, 0, 0, 0, 0, 10 + k, 7 - k);
    op_exp(0, POP, 0, 0, 0, 1, 0, 0);
    chk("empty_after_underflow", empty, 1'b1);

    // wrap: push 8, pop 5, push 5, then read all indices
    for (int k = 0; k < 8; k++) op_exp(0, PUSH, 20 + k, 0, 0, 0, 0, k + 1);
    for (int k = 0; k < 5; k++) op_exp(0, POP, 0, 0, 0, 0, 20 + k, 7 - k);
    for (int k = 0; k < 5; k++) op_exp(0, PUSH, 30 + k, 0, 0, 0, 0, 4 + k);
    for (int k = 0; k < 8; k++) op_exp(1, READ, 0, k, 1, 0, rd_tab[k], 8);
    op_exp(0, POP, 0, 0, 0, 0, 25, 7);
    op_exp(0, READ, 0, 7, 0, 1, 0, 7);   // index == count
    op_exp(0, READ, 0, 6, 0, 0, 34, 7);

    // NOP on req0 is ignored while req1 pushes
    rv[0] = 1'b1; rop[0] = NOP;
    expect_rsp(1, 0, 0, 8);
    fork
      do_op(1, PUSH, 40, 0);
      begin @(negedge clk); chk("nop_ready", req_ready, 2'b10); end
    join
    // priority moved only by the req1 accept: req0 wins next
    expect_rsp(0, 0, 26, 7);
    expect_rsp(1, 0, 27, 6);
    fork
      do_op(0, POP, 0, 0);
      do_op(1, POP, 0, 0);
    join

    // reset mid-operation with q_size=4 and a response in flight
    op_exp(0, POP, 0, 0, 0, 0, 30, 5);
    expect_rsp(1, 0, 31, 4);
    rv[1] = 1'b1; rop[1] = POP;
    @(negedge clk);
    chk("pre_reset_ready", req_ready, 2'b10);
    @(posedge clk); #1;
    rv[1] = 1'b0; rop[1] = NOP;
    @(negedge clk);
    #2;
    rst = 1'b1;
    rv[0] = 1'b1; rop[0] = PUSH;
    #1;
    chk("async_rst_rsp_valid", rsp_valid, 1'b0);
    chk("async_rst_q_size", q_size, 0);
    chk("async_rst_empty", empty, 1'b1);
    chk("async_rst_full", full, 1'b0);
    chk("async_rst_ready", req_ready, 2'b00);
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0;
    rv[0] = 1'b0; rop[0] = NOP;
    @(posedge clk); #1;
    op_exp(1, POP, 0, 0, 1, 1, 0, 0);

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // hard stop in case anything stalls outside the bounded driver loops
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, need finish before 200000 time units");
    $fatal(1, "watchdog");
  end

endmodule
